vx_scan_pipe: RTL

VX_SCAN_PIPE -- requirements
Module: VX_scan_pipe

---
 rtl/vx_scan_pkg.sv | 21 ++
 rtl/vx_scan_level.sv | 31 +++
 rtl/vx_scan_pipe.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/vx_scan_pkg.sv
// vx_scan_pkg: shared definitions for the scan pipeline.
//   SCAN_OP_W   - width of the per-beat operator field
//   scan_op_e   - operator encodings (XOR, AND, OR, COPY)
//   scan_fill() - bit shifted in at the low end of a shift-combine level
package vx_scan_pkg;

    localparam int unsigned SCAN_OP_W = 2;

    typedef enum logic [SCAN_OP_W-1:0] {
        SCAN_OP_XOR  = 2'd0,
        SCAN_OP_AND  = 2'd1,
        SCAN_OP_OR   = 2'd2,
        SCAN_OP_COPY = 2'd3
    } scan_op_e;

    // Identity element of the operator, so the fill never changes a result bit.
    function automatic logic scan_fill(input logic [SCAN_OP_W-1:0] op);
        return op == SCAN_OP_AND;
    endfunction

endpackage

// File: rtl/vx_scan_level.sv
// vx_scan_level: one Kogge-Stone shift-combine level (purely combinational).
//   N      - data width
//   SHIFT  - distance to the combined partner bit (must be < N)
//   data   - input partial scan (LO->HI order)
//   op     - operator; COPY passes data through untouched
//   result - data[i] op data[i-SHIFT], low SHIFT bits combined with the fill
module vx_scan_level
    import vx_scan_pkg::*;
#(
    parameter int unsigned N     = 8,
    parameter int unsigned SHIFT = 1
) (
    input  logic [N-1:0]         data,
    input  logic [SCAN_OP_W-1:0] op,
    output logic [N-1:0]         result
);

    logic [N-1:0] shifted;

    // Shift towards HI, filling the vacated low bits with the identity value.
    always_comb begin
        shifted = {data[N-SHIFT-1:0], {SHIFT{scan_fill(op)}}};
        case (op)
            SCAN_OP_XOR: result = data ^ shifted;
            SCAN_OP_AND: result = data & shifted;
            SCAN_OP_OR:  result = data | shifted;
            default:     result = data;
        endcase
    end

endmodule

// File: rtl/vx_scan_pipe.sv
// vx_scan_pipe: pipelined inclusive bit-scan (XOR/AND/OR/COPY) with a
// valid/ready handshake on both sides.
//   clk, reset_n                     - clock, async active-low reset
//   valid_in/ready_in                - input handshake (ready_in = global enable)
//   data_in, op_in, rev_in, tag_in   - beat payload; rev_in=1 scans HI->LO
//   valid_out/ready_out              - output handshake
//   data_out, tag_out                - scan result and the beat's own tag
//   perf_stalls                      - present only with VX_SCAN_PERF_EN:
//                                      saturating count of back-pressured cycles
// HI->LO scans are done by reversing the bits, scanning LO->HI and reversing back.
module vx_scan_pipe
    import vx_scan_pkg::*;
#(
    parameter int unsigned N              = 8,
    parameter int unsigned LVLS_PER_STAGE = 1,
    parameter int unsigned TAG_W          = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 valid_in,
    output logic                 ready_in,
    input  logic [N-1:0]         data_in,
    input  logic [SCAN_OP_W-1:0] op_in,
    input  logic                 rev_in,
    input  logic [TAG_W-1:0]     tag_in,
    output logic                 valid_out,
    input  logic                 ready_out,
    output logic [N-1:0]         data_out,
    output logic [TAG_W-1:0]     tag_out
`ifdef VX_SCAN_PERF_EN
    ,
    output logic [31:0]          perf_stalls
`endif
);

    localparam int unsigned LOGN = $clog2(N);
    localparam int unsigned S    = (LOGN == 0) ? 1 : (LOGN + LVLS_PER_STAGE - 1) / LVLS_PER_STAGE;
    localparam int unsigned SP   = (S > 1) ? S - 1 : 1;

    logic                 en;
    logic [N-1:0]         data_in_ord;
    logic [N-1:0]         stg_in  [S];
    logic [SCAN_OP_W-1:0] stg_op  [S];
    logic [N-1:0]         stg_res [S];

    // Inter-stage registers; the last stage feeds the output register directly.
    logic [N-1:0]         pipe_data  [SP];
    logic [SCAN_OP_W-1:0] pipe_op    [SP];
    logic                 pipe_rev   [SP];
    logic [TAG_W-1:0]     pipe_tag   [SP];
    logic                 pipe_valid [SP];

    logic                 last_valid;
    logic                 last_rev;
    logic [TAG_W-1:0]     last_tag;
    logic [N-1:0]         result_c;

    // Whole pipe moves together; only a held output blocks it.
    assign en       = !valid_out || ready_out;
    assign ready_in = en;

    // Put the input into LO->HI scan order.
    always_comb begin
        data_in_ord = data_in;
        if (rev_in) begin
            for (int i = 0; i < N; i++) begin
                data_in_ord[i] = data_in[N-1-i];
            end
        end
    end

    // Stage inputs: stage 0 from the ports, later stages from their registers.
    for (genvar s = 0; s < S; s++) begin : g_stg_in
        if (s == 0) begin : g_head
            assign stg_in[s] = data_in_ord;
            assign stg_op[s] = op_in;
        end else begin : g_tail
            assign stg_in[s] = pipe_data[s-1];
            assign stg_op[s] = pipe_op[s-1];
        end
    end

    // Shift-combine levels, LVLS_PER_STAGE per stage, shift doubling each level.
    if (LOGN == 0) begin : g_nolvl
        assign stg_res[0] = stg_in[0];
    end else begin : g_lvl
        logic [N-1:0] lvl_in  [LOGN];
        logic [N-1:0] lvl_out [LOGN];

        for (genvar k = 0; k < LOGN; k++) begin : g_k
            localparam int unsigned ST = k / LVLS_PER_STAGE;

            if (k % LVLS_PER_STAGE == 0) begin : g_first
                assign lvl_in[k] = stg_in[ST];
            end else begin : g_chain
                assign lvl_in[k] = lvl_out[k-1];
            end

            vx_scan_level #(
                .N     (N),
                .SHIFT (1 << k)
            ) u_level (
                .data   (lvl_in[k]),
                .op     (stg_op[ST]),
                .result (lvl_out[k])
            );

            if ((k % LVLS_PER_STAGE == LVLS_PER_STAGE - 1) || (k == LOGN - 1)) begin : g_end
                assign stg_res[ST] = lvl_out[k];
            end
        end
    end

    // Stage valid bits are the only internal state needing reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SP; i++) begin
                pipe_valid[i] <= 1'b0;
            end
        end else if (en) begin
            pipe_valid[0] <= valid_in;
            for (int i = 1; i < SP; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
            end
        end
    end

    // Per-beat payload and controls travel alongside the valid bits.
    always_ff @(posedge clk) begin
        if (en) begin
            pipe_rev[0] <= rev_in;
            pipe_tag[0] <= tag_in;
            for (int i = 1; i < SP; i++) begin
                pipe_rev[i] <= pipe_rev[i-1];
                pipe_tag[i] <= pipe_tag[i-1];
            end
            for (int i = 0; i < SP; i++) begin
                pipe_data[i] <= stg_res[i];
                pipe_op[i]   <= stg_op[i];
            end
        end
    end

    if (S == 1) begin : g_last_port
        assign last_valid = valid_in;
        assign last_rev   = rev_in;
        assign last_tag   = tag_in;
    end else begin : g_last_pipe
        assign last_valid = pipe_valid[S-2];
        assign last_rev   = pipe_rev[S-2];
        assign last_tag   = pipe_tag[S-2];
    end

    // Undo the input reversal for HI->LO beats.
    always_comb begin
        result_c = stg_res[S-1];
        if (last_rev) begin
            for (int i = 0; i < N; i++) begin
                result_c[i] = stg_res[S-1][N-1-i];
            end
        end
    end

    // Output register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_out <= 1'b0;
            data_out  <= '0;
            tag_out   <= '0;
        end else if (en) begin
            valid_out <= last_valid;
            data_out  <= result_c;
            tag_out   <= last_tag;
        end
    end

`ifdef VX_SCAN_PERF_EN
    // Back-pressure cycle counter, saturating.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_stalls <= '0;
        end else if (valid_out && !ready_out && (perf_stalls != '1)) begin
            perf_stalls <= perf_stalls + 32'd1;
        end
    end
`endif

endmodule
